// File: rtl/cpu_types_pkg.sv
// Shared CPU types: PC sequencer state encoding and next-PC select codes.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    MEM    = 2'd1,
    HALTED = 2'd2
  } pcseq_state_t;

  localparam logic [1:0] PCSRC_JR  = 2'd0;
  localparam logic [1:0] PCSRC_J   = 2'd1;
  localparam logic [1:0] PCSRC_BR  = 2'd2;
  localparam logic [1:0] PCSRC_SEQ = 2'd3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/memory handshake bundle between the PC sequencer and the rest of the core.
interface pc_sequencer_if;

  logic       ihit;
  logic       dhit;
  logic       ctr_dREN;
  logic       ctr_dWEN;
  logic       ctr_halt;
  logic [1:0] ctr_pcsrc;
  logic       pc_en;
  logic [1:0] pcsrc;
  logic       imemREN;
  logic       dmemREN;
  logic       dmemWEN;
  logic       halt;

  // Sequencer side
  modport slave (
    input  ihit, dhit, ctr_dREN, ctr_dWEN, ctr_halt, ctr_pcsrc,
    output pc_en, pcsrc, imemREN, dmemREN, dmemWEN, halt
  );

  // Core / environment side
  modport master (
    output ihit, dhit, ctr_dREN, ctr_dWEN, ctr_halt, ctr_pcsrc,
    input  pc_en, pcsrc, imemREN, dmemREN, dmemWEN, halt
  );

endinterface

// File: rtl/pc_sequencer_retire_counter.sv
// Wrapping retired-instruction counter, cleared asynchronously by nRST.
module retire_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetch, optional data access, sticky halt.
// Optional retired-instruction counter enabled by macro PC_SEQ_PERF_EN.
module pc_sequencer
  import cpu_types_pkg::*;
`ifdef PC_SEQ_PERF_EN
#(
  parameter int RETIRE_CNT_W = 32
)
`endif
(
  input  logic              CLK,
  input  logic              nRST,
  pc_sequencer_if.slave     bus
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [RETIRE_CNT_W-1:0] retire_cnt
`endif
);

  pcseq_state_t state_reg;
  pcseq_state_t state_next;
  logic         advance;
  logic         pc_en_int;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    advance     = 1'b0;
    bus.imemREN = 1'b0;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.halt    = 1'b0;
    case (state_reg)
      FETCH: begin
        bus.imemREN = 1'b1;
        if (bus.ihit) begin
          // Halt wins over a simultaneous load/store decode.
          if (bus.ctr_halt) begin
            state_next = HALTED;
          end else if (bus.ctr_dREN || bus.ctr_dWEN) begin
            state_next = MEM;
          end else begin
            advance = 1'b1;
          end
        end
      end
      MEM: begin
        // Both strobes decoded means store.
        bus.dmemWEN = bus.ctr_dWEN;
        bus.dmemREN = bus.ctr_dREN && !bus.ctr_dWEN;
        if (bus.dhit) begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      HALTED: begin
        bus.halt = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Reset gates the strobe so an ihit during reset cannot advance the PC.
  assign pc_en_int = advance && nRST;
  assign bus.pc_en = pc_en_int;
  assign bus.pcsrc = pc_en_int ? bus.ctr_pcsrc : PCSRC_SEQ;

`ifdef PC_SEQ_PERF_EN
  retire_counter #(
    .WIDTH (RETIRE_CNT_W)
  ) u_retire_counter (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (pc_en_int),
    .count (retire_cnt)
  );
`endif

endmodule
